// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_ILLEGAL  = 2'd1,
        FC_MISALIGN = 2'd2,
        FC_BUS      = 2'd3
    } fault_cause_e;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// Module   : fetch_sequencer
// Brief    : Owns the PC, issues one imem read at a time and hands the returned
//            word to decode; handles redirects and halts on faults.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            halted,
    output logic [1:0]      fault_cause,
    output logic [XLEN-1:0] fault_pc
);

    fetch_state_e    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_drop, w_drop_nxt;
    logic [ILEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    fault_cause_e    r_fault_cause, w_fault_cause_nxt;
    logic [XLEN-1:0] r_fault_pc, w_fault_pc_nxt;
    logic            w_capture;
    logic            w_fault_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_drop        <= 1'b0;
            r_inst        <= '0;
            r_inst_pc     <= '0;
            r_fault_cause <= FC_NONE;
            r_fault_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            if (w_capture) begin
                r_inst    <= imem_resp_data;
                r_inst_pc <= r_pc;
            end
            if (w_fault_we) begin
                r_fault_cause <= w_fault_cause_nxt;
                r_fault_pc    <= w_fault_pc_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drop_nxt        = r_drop;
        w_capture         = 1'b0;
        w_fault_we        = 1'b0;
        w_fault_cause_nxt = FC_NONE;
        w_fault_pc_nxt    = '0;
        imem_req_valid    = 1'b0;
        inst_valid        = 1'b0;
        halted            = 1'b0;

        case (r_state)
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else if (imem_resp_err) begin
                        w_fault_we        = 1'b1;
                        w_fault_cause_nxt = FC_BUS;
                        w_fault_pc_nxt    = r_pc;
                        w_state_nxt       = S_HALT;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    if (inst_fault) begin
                        w_fault_we        = 1'b1;
                        w_fault_cause_nxt = FC_ILLEGAL;
                        w_fault_pc_nxt    = r_inst_pc;
                        w_state_nxt       = S_HALT;
                    end else begin
                        w_pc_nxt    = r_pc + XLEN'(INST_BYTES);
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase

        // A redirect overrides whatever the state logic decided above.
        if (redirect_valid && r_state != S_HALT) begin
            w_capture = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                w_fault_we        = 1'b1;
                w_fault_cause_nxt = FC_MISALIGN;
                w_fault_pc_nxt    = redirect_pc;
                w_drop_nxt        = 1'b0;
                w_state_nxt       = S_HALT;
            end else begin
                w_fault_we  = 1'b0;
                w_pc_nxt    = redirect_pc;
                w_drop_nxt  = 1'b0;
                w_state_nxt = S_REQ;
                // A request already in flight must have its response swallowed.
                if ((r_state == S_REQ && imem_req_ready) ||
                    (r_state == S_WAIT && !imem_resp_valid)) begin
                    w_drop_nxt  = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
        end
    end

    assign imem_addr   = r_pc;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
    assign fault_cause = r_fault_cause;
    assign fault_pc    = r_fault_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// Module   : tb_fetch_sequencer
// Brief    : Directed self-checking bench for fetch_sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;

    int r_pass  = 0;
    int r_total = 0;

    fetch_sequencer #(
        .XLEN     (32),
        .ILEN     (32),
        .RESET_PC (C_RESET_PC)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_fault      (inst_fault),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halted          (halted),
        .fault_cause     (fault_cause),
        .fault_pc        (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hA5A5_0000 ^ {addr[15:0], addr[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_total++;
        assert (obs === exp) begin
            r_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // One full fetch starting in S_REQ: request, 1-cycle response, decode accept.
    task automatic do_fetch(input logic [31:0] addr);
        chk("req_valid", 32'(imem_req_valid), 32'd1);
        chk("req_addr", imem_addr, addr);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(addr);
        step();
        imem_resp_valid = 1'b0;
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst", inst, mem_word(addr));
        chk("inst_pc", inst_pc, addr);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        inst_ready      = 1'b0;
        inst_fault      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;

        // Reset state
        do_reset();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_addr", imem_addr, C_RESET_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);

        // Sequential fetch
        do_fetch(32'h100);
        do_fetch(32'h104);
        do_fetch(32'h108);

        // Decode backpressure
        chk("bp_addr", imem_addr, 32'h10C);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(32'h10C);
        step();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_inst_valid", 32'(inst_valid), 32'd1);
            chk("bp_inst", inst, mem_word(32'h10C));
            chk("bp_inst_pc", inst_pc, 32'h10C);
            chk("bp_no_req", 32'(imem_req_valid), 32'd0);
            step();
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("bp_next_addr", imem_addr, 32'h110);

        // Redirect while a request is outstanding
        do_reset();
        do_fetch(32'h100);
        chk("rd_addr", imem_addr, 32'h104);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk("rd_wait_no_req", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(32'h104);
        step();
        imem_resp_valid = 1'b0;
        chk("rd_no_inst", 32'(inst_valid), 32'd0);
        do_fetch(32'h200);

        // Redirect on the request handshake; the erroring response is dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_err   = 1'b1;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        chk("drop_err_halted", 32'(halted), 32'd0);
        chk("drop_err_inst_valid", 32'(inst_valid), 32'd0);
        chk("drop_err_addr", imem_addr, 32'h300);

        // Misaligned redirect halts; later redirects ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        step();
        chk("mis_halted", 32'(halted), 32'd1);
        chk("mis_cause", 32'(fault_cause), 32'd2);
        chk("mis_fault_pc", fault_pc, 32'h202);
        redirect_pc = 32'h400;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_no_req", 32'(imem_req_valid), 32'd0);
            chk("halt_fault_pc", fault_pc, 32'h202);
        end
        redirect_valid = 1'b0;
        do_reset();
        chk("rs_halted", 32'(halted), 32'd0);
        chk("rs_cause", 32'(fault_cause), 32'd0);
        do_fetch(32'h100);

        // Illegal instruction at 0x10C
        do_fetch(32'h104);
        do_fetch(32'h108);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(32'h10C);
        step();
        imem_resp_valid = 1'b0;
        inst_ready = 1'b1;
        inst_fault = 1'b1;
        step();
        inst_ready = 1'b0;
        inst_fault = 1'b0;
        chk("ill_halted", 32'(halted), 32'd1);
        chk("ill_cause", 32'(fault_cause), 32'd1);
        chk("ill_fault_pc", fault_pc, 32'h10C);
        chk("ill_inst_valid", 32'(inst_valid), 32'd0);

        // Bus error at 0x110
        do_reset();
        do_fetch(32'h100);
        do_fetch(32'h104);
        do_fetch(32'h108);
        do_fetch(32'h10C);
        chk("bus_addr", imem_addr, 32'h110);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_err   = 1'b1;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        chk("bus_halted", 32'(halted), 32'd1);
        chk("bus_cause", 32'(fault_cause), 32'd3);
        chk("bus_fault_pc", fault_pc, 32'h110);

        // PC wrap
        do_reset();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        do_fetch(32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset mid S_WAIT; the late response is ignored
        step();
        chk("mid_wait_no_req", 32'(imem_req_valid), 32'd0);
        do_reset();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        chk("late_req_valid", 32'(imem_req_valid), 32'd1);
        chk("late_addr", imem_addr, C_RESET_PC);
        step();
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        chk("late_inst_valid", 32'(inst_valid), 32'd0);
        do_fetch(32'h100);

        $display("%0d/%0d checks passed", r_pass, r_total);
        $finish;
    end

endmodule

`default_nettype wire
